// File: rtl/code_fetch.sv
// code_fetch: instruction fetch stage between the code RAM and core decode.
//   Walks the PC forward one word per cycle, accounts for the RAM's one-cycle
//   synchronous read latency with a single in-flight tag, and queues fetched
//   words in a small prefetch FIFO that decode drains over valid/ready.
//   A redirect flushes the FIFO, drops any in-flight word and restarts at
//   redirect_pc.
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   running                1 = new fetches may be issued
//   redirect_valid/_pc     flush and restart fetching at redirect_pc
//   ram_addr               code RAM address (registered fetch PC)
//   ram_read               RAM data for the address presented last cycle
//   instr_valid/_data/_pc  FIFO head offered to decode
//   instr_ready            decode takes the head this cycle
module code_fetch #(
   parameter int                    WIDTH      = 16,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  running,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [WIDTH-1:0]      ram_read,
   output logic                  instr_valid,
   output logic [WIDTH-1:0]      instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [WIDTH-1:0]      data;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic                  pending_q, pending_d;
   logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;
   entry_t [DEPTH-1:0]    fifo_q, fifo_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [CNT_W:0]        credit;

   always_comb begin
      pop    = (count_q != '0) && instr_ready;
      push   = pending_q;
      // Occupancy once this cycle settles, counting the word still in the
      // RAM pipe; issuing only below DEPTH means a push never meets a full FIFO.
      credit = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q} - {{CNT_W{1'b0}}, pop};
      issue  = running && !redirect_valid && (credit < (CNT_W+1)'(DEPTH));

      fetch_pc_d   = fetch_pc_q;
      pending_d    = 1'b0;
      pending_pc_d = pending_pc_q;
      fifo_d       = fifo_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;

      if (redirect_valid) begin
         // Flush wins over everything; a pop this cycle has already been
         // taken by decode, the in-flight word is simply never written.
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            pending_d    = 1'b1;
            pending_pc_d = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + ADDR_WIDTH'(1);
         end
         if (push) begin
            fifo_d[wr_ptr_q] = '{data: ram_read, pc: pending_pc_q};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         pending_q    <= 1'b0;
         pending_pc_q <= '0;
         fifo_q       <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         pending_q    <= pending_d;
         pending_pc_q <= pending_pc_d;
         fifo_q       <= fifo_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

   // ram_addr comes straight from a flop: no path from ready/redirect.
   assign ram_addr    = fetch_pc_q;
   assign instr_valid = (count_q != '0);
   assign instr_data  = fifo_q[rd_ptr_q].data;
   assign instr_pc    = fifo_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_code_fetch.sv
module tb_code_fetch;

   typedef struct packed {
      logic [15:0] data;
      logic [15:0] pc;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        running;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] ram_addr, ram_addr_w;
   logic [15:0] ram_read, ram_read_w;
   logic        instr_valid, instr_valid_w;
   logic [15:0] instr_data, instr_data_w;
   logic [15:0] instr_pc, instr_pc_w;
   logic        instr_ready, ready_w;

   exp_t sb[$];
   exp_t sb_w[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   code_fetch #(.WIDTH(16), .ADDR_WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clock(clock), .reset(reset), .running(running),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ram_addr(ram_addr), .ram_read(ram_read),
      .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   // Second instance exercising PC wrap from a reset PC near the top.
   code_fetch #(.WIDTH(16), .ADDR_WIDTH(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
      .clock(clock), .reset(reset), .running(running),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .ram_addr(ram_addr_w), .ram_read(ram_read_w),
      .instr_valid(instr_valid_w), .instr_data(instr_data_w), .instr_pc(instr_pc_w),
      .instr_ready(ready_w)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] ram_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'hff00;
         16'h0001: return 16'h0f0f;
         16'h0002: return 16'h1234;
         16'h0003: return 16'habcd;
         default:  return {a[7:0], a[15:8]} ^ 16'h5ac3;
      endcase
   endfunction

   function automatic exp_t mk(input logic [15:0] pc);
      return '{data: ram_word(pc), pc: pc};
   endfunction

   // Synchronous code RAM models: one cycle read latency.
   always @(posedge clock) begin
      ram_read   <= ram_word(ram_addr);
      ram_read_w <= ram_word(ram_addr_w);
   end

   // Scoreboards: every word decode accepts must be the next expected one.
   always @(negedge clock) begin
      if (instr_valid && instr_ready) begin
         exp_t e;
         n_tests++;
         if (sb.size() == 0) begin
            assert (0) else begin
               n_fail++;
               $error("FAIL pop_unexpected observed pc=%h data=%h expected none", instr_pc, instr_data);
            end
         end else begin
            e = sb.pop_front();
            assert ({instr_data, instr_pc} === e) else begin
               n_fail++;
               $error("FAIL pop observed data=%h pc=%h expected data=%h pc=%h",
                      instr_data, instr_pc, e.data, e.pc);
            end
         end
      end
   end

   always @(negedge clock) begin
      if (instr_valid_w && ready_w) begin
         exp_t e;
         n_tests++;
         if (sb_w.size() == 0) begin
            assert (0) else begin
               n_fail++;
               $error("FAIL pop_w_unexpected observed pc=%h data=%h expected none", instr_pc_w, instr_data_w);
            end
         end else begin
            e = sb_w.pop_front();
            assert ({instr_data_w, instr_pc_w} === e) else begin
               n_fail++;
               $error("FAIL pop_w observed data=%h pc=%h expected data=%h pc=%h",
                      instr_data_w, instr_pc_w, e.data, e.pc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      running        = 1'b0;
      instr_ready    = 1'b0;
      ready_w        = 1'b0;
      redirect_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset          = 1'b1;
      running        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      instr_ready    = 1'b0;
      ready_w        = 1'b0;
      tick();
      tick();
      chk("rst_valid",   32'(instr_valid),   32'd0);
      chk("rst_addr",    32'(ram_addr),      32'h0000);
      chk("rst_valid_w", 32'(instr_valid_w), 32'd0);
      chk("rst_addr_w",  32'(ram_addr_w),    32'hfffe);
      reset = 1'b0;

      // 1: latency and back-to-back delivery; wrap on the second instance
      for (int i = 0; i < 4; i++) sb.push_back(mk(16'(i)));
      for (int i = 0; i < 4; i++) sb_w.push_back(mk(16'hfffe + 16'(i)));
      running     = 1'b1;
      instr_ready = 1'b1;
      ready_w     = 1'b1;
      chk("t1_c0_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("t1_c1_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("t1_c2_valid",   32'(instr_valid),   32'd1);
      chk("t1_c2_valid_w", 32'(instr_valid_w), 32'd1);
      repeat (4) tick();
      instr_ready = 1'b0;
      ready_w     = 1'b0;
      chk("t1_sb_empty",   32'(sb.size()),   32'd0);
      chk("t1_sb_w_empty", 32'(sb_w.size()), 32'd0);

      // 2: backpressure fills the FIFO, then drains in order
      do_reset();
      running = 1'b1;
      repeat (8) tick();
      chk("t2_addr_sat", 32'(ram_addr),    32'h0004);
      chk("t2_valid",    32'(instr_valid), 32'd1);
      chk("t2_head_pc",  32'(instr_pc),    32'h0000);
      tick();
      chk("t2_addr_hold", 32'(ram_addr),   32'h0004);
      chk("t2_head_data", 32'(instr_data), 32'hff00);
      for (int i = 0; i < 10; i++) sb.push_back(mk(16'(i)));
      instr_ready = 1'b1;
      repeat (10) tick();
      instr_ready = 1'b0;
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);

      // 3: redirect with count=3, pending=1; pop in the redirect cycle is taken
      do_reset();
      running = 1'b1;
      repeat (4) tick();
      chk("t3_pre_addr",  32'(ram_addr),    32'h0004);
      chk("t3_pre_valid", 32'(instr_valid), 32'd1);
      sb.push_back(mk(16'h0000));
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0010;
      instr_ready    = 1'b1;
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      chk("t3_flush_valid", 32'(instr_valid), 32'd0);
      chk("t3_flush_addr",  32'(ram_addr),    32'h0010);
      tick();
      chk("t3_gap_valid", 32'(instr_valid), 32'd0);
      tick();
      chk("t3_new_valid", 32'(instr_valid), 32'd1);
      sb.push_back(mk(16'h0010));
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);

      // 3b: back-to-back redirects, last one wins
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0020;
      tick();
      redirect_pc = 16'h0030;
      tick();
      redirect_valid = 1'b0;
      chk("t3b_valid", 32'(instr_valid), 32'd0);
      chk("t3b_addr",  32'(ram_addr),    32'h0030);
      sb.push_back(mk(16'h0030));
      sb.push_back(mk(16'h0031));
      instr_ready = 1'b1;
      tick();
      chk("t3b_gap_valid", 32'(instr_valid), 32'd0);
      repeat (3) tick();
      instr_ready = 1'b0;
      chk("t3b_sb_empty", 32'(sb.size()), 32'd0);

      // 4: running drops after pc 5 issues; in-flight word still delivered
      do_reset();
      running     = 1'b1;
      instr_ready = 1'b1;
      for (int i = 0; i < 6; i++) sb.push_back(mk(16'(i)));
      repeat (6) tick();
      running = 1'b0;
      repeat (2) tick();
      chk("t4_sb_empty", 32'(sb.size()), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("t4_idle_valid", 32'(instr_valid), 32'd0);
         chk("t4_idle_addr",  32'(ram_addr),    32'h0006);
         tick();
      end
      running = 1'b1;
      sb.push_back(mk(16'h0006));
      sb.push_back(mk(16'h0007));
      repeat (4) tick();
      instr_ready = 1'b0;
      chk("t4_resume_empty", 32'(sb.size()), 32'd0);

      // 6: reset with a full FIFO drops everything, restarts at RESET_PC
      repeat (6) tick();
      chk("t6_full_valid", 32'(instr_valid), 32'd1);
      reset = 1'b1;
      tick();
      chk("t6_rst_valid",  32'(instr_valid), 32'd0);
      chk("t6_rst_addr",   32'(ram_addr),    32'h0000);
      chk("t6_rst_addr_w", 32'(ram_addr_w),  32'hfffe);
      reset       = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(mk(16'(i)));
      repeat (5) tick();
      instr_ready = 1'b0;
      running     = 1'b0;
      chk("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
